pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
- Program-counter sequencer that consumes the registered `isBranch` flag produced by the branch comparator.
- Redirects fetch to the branch target or continues sequentially.
- Sits between decode (which issues branch ops and targets) and instruction fetch.
- Absorbs the comparator's one-cycle registered latency with a resolve state, emits a one-cycle flush on taken branches, and keeps branch statistics.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, sequential PC increment in bytes.
- CNT_W, 16, width of the branch statistics counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising clk edge.
- stall  in  1  hold PC while in RUN.
- halt  in  1  request to stop fetch permanently until reset.
- br_issue  in  1  decode presents a branch op (brOp != 0) this cycle.
- br_target  in  32  branch target address, valid with br_issue.
- isBranch  in  1  comparator result; valid the cycle after br_issue.
- pc  out  32  current fetch address.
- fetch_valid  out  1  pc is a valid fetch request this cycle.
- flush  out  1  one-cycle pulse: discard the wrong-path instruction.
- halted  out  1  unit is in HALT.
- misalign_err  out  1  sticky: a taken target had nonzero bits [1:0].
- br_count  out  CNT_W  number of branches resolved (saturating).
- taken_count  out  CNT_W  number of taken branches (saturating).

Behaviour:
- Reset (rst==0 at edge) applies regardless of state, including mid-RESOLVE:
  - pc=RESET_PC, state=RUN, fetch_valid=0, flush=0, halted=0, misalign_err=0, both counters=0.
  - Any captured target is discarded.
- First cycle after reset release: fetch_valid=1.
- All outputs are registered.
- RUN, checked in this priority order:
  - halt=1 -> HALT, fetch_valid=0. Halt beats a simultaneous br_issue; that branch is dropped and not counted.
  - stall=1 -> pc held, fetch_valid=1, br_issue ignored. Decode must re-present it after the stall.
  - br_issue=1 -> capture br_target into target_q, pc held, fetch_valid=0, go RESOLVE.
  - Otherwise -> pc<=pc+PC_INC (modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0), fetch_valid=1.
- RESOLVE (always exactly one cycle; samples isBranch; stall and halt ignored):
  - br_count increments.
  - isBranch=1 with target_q[1:0]==0:
    - pc<=target_q, flush=1 for this one cycle, taken_count increments.
    - fetch_valid=1, go RUN.
  - isBranch=1 with target_q[1:0]!=0:
    - misalign_err<=1, pc unchanged, flush=1, taken_count increments.
    - Go HALT.
  - isBranch=0: pc<=pc+PC_INC, flush=0, fetch_valid=1, go RUN.
- HALT:
  - pc frozen, fetch_valid=0, halted=1, flush=0.
  - Exits only via reset.
- flush is never high for more than one consecutive cycle.
- Counters saturate at 2^CNT_W-1; they never wrap.
- Latency:
  - Not-taken branch costs 1 bubble cycle.
  - Taken branch costs 1 bubble cycle plus the flush pulse.
  - Redirected pc is visible 2 edges after br_issue is sampled.

Decomposition:
- Shared package pc_pkg:
  - state encoding RUN=2'b00, RESOLVE=2'b01, HALT=2'b10;
  - PC_INC and RESET_PC defaults;
  - brOp code constants (001 always, 010 sign, 011 sign, 100 zero), so decode and this unit agree.
- One sub-module: sat_counter (parameter W; ports clk, rst, inc, count), instantiated twice for br_count and taken_count.

Test Plan:
- Reset release, no branches, 4 cycles -> pc 0,4,8,12; fetch_valid=1; flush=0.
- br_issue at pc=8 with br_target=32'h40, isBranch=1 next cycle:
  - pc stays 8 for one cycle, then 32'h40;
  - flush=1 for exactly one cycle;
  - br_count=1, taken_count=1.
- br_issue at pc=8 with br_target=32'h40, isBranch=0 -> pc 8,8,12; flush stays 0; br_count=1, taken_count=0.
- Taken branch with br_target=32'h42 -> misalign_err=1, halted=1, pc stays at the branch pc, fetch_valid=0 until reset.
- halt and br_issue asserted together in RUN -> HALT immediately; br_count unchanged. Also: rst=0 during RESOLVE -> next cycle pc=RESET_PC, state RUN, counters 0, no flush.
- Preload pc=32'hFFFF_FFFC, no branch -> pc=0. With CNT_W=2, 5 taken branches -> taken_count saturates at 3.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the PC redirect path: FSM encoding, PC defaults,
// and the brOp codes that decode and this unit must agree on.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_RESOLVE = 2'b01,
    ST_HALT    = 2'b10
  } pc_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INC_DEFAULT   = 4;
  localparam int unsigned CNT_W_DEFAULT    = 16;

  // brOp encodings issued by decode; 3'b000 means "not a branch"
  localparam logic [2:0] BROP_NONE   = 3'b000;
  localparam logic [2:0] BROP_ALWAYS = 3'b001;
  localparam logic [2:0] BROP_SIGN_A = 3'b010;
  localparam logic [2:0] BROP_SIGN_B = 3'b011;
  localparam logic [2:0] BROP_ZERO   = 3'b100;

  // A redirect target is only usable when it is word aligned
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count up on inc, stop at the maximum value; synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC sequencer: steps sequentially, or redirects to a branch target
// once the comparator's registered verdict arrives one cycle after issue.
//
// state   | meaning
// RUN     | normal fetch; sequential step, stall hold, or accept a branch
// RESOLVE | one-cycle wait for isBranch, then redirect / continue / fault
// HALT    | fetch stopped until reset
module pc_redirect_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
  parameter int unsigned PC_INC   = PC_INC_DEFAULT,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_issue,
  input  logic [31:0]      br_target,
  input  logic             isBranch,
  output logic [31:0]      pc,
  output logic             fetch_valid,
  output logic             flush,
  output logic             halted,
  output logic             misalign_err,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [31:0] PcStep = 32'(PC_INC);

  pc_state_e   state_q;
  logic [31:0] pc_q;
  logic [31:0] target_q;
  logic        fetch_valid_q;
  logic        flush_q;
  logic        halted_q;
  logic        misalign_q;
  logic [31:0] pc_seq_d;
  logic        br_inc_d;
  logic        taken_inc_d;

  // Sequential successor of the current PC; wraps modulo 2^32
  always_comb begin
    pc_seq_d = pc_q + PcStep;
  end

  // Counter strobes: every RESOLVE resolves one branch, isBranch marks it taken
  always_comb begin
    br_inc_d    = (state_q == ST_RESOLVE);
    taken_inc_d = (state_q == ST_RESOLVE) && isBranch;
  end

  // Control FSM with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      target_q      <= '0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      halted_q      <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (halt) begin
            state_q       <= ST_HALT;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b1;
          end else if (stall) begin
            fetch_valid_q <= 1'b1;
          end else if (br_issue) begin
            target_q      <= br_target;
            fetch_valid_q <= 1'b0;
            state_q       <= ST_RESOLVE;
          end else begin
            // Coming out of reset the PC has not been fetched yet, so the
            // first RUN cycle presents it instead of stepping past it.
            if (fetch_valid_q) begin
              pc_q <= pc_seq_d;
            end
            fetch_valid_q <= 1'b1;
          end
        end
        ST_RESOLVE: begin
          if (isBranch) begin
            flush_q <= 1'b1;
            if (is_word_aligned(target_q)) begin
              pc_q          <= target_q;
              fetch_valid_q <= 1'b1;
              state_q       <= ST_RUN;
            end else begin
              misalign_q    <= 1'b1;
              fetch_valid_q <= 1'b0;
              halted_q      <= 1'b1;
              state_q       <= ST_HALT;
            end
          end else begin
            pc_q          <= pc_seq_d;
            fetch_valid_q <= 1'b1;
            state_q       <= ST_RUN;
          end
        end
        ST_HALT: begin
          fetch_valid_q <= 1'b0;
          halted_q      <= 1'b1;
        end
        default: begin
          state_q       <= ST_HALT;
          fetch_valid_q <= 1'b0;
          halted_q      <= 1'b1;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_inc_d),
    .count (br_count)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (taken_inc_d),
    .count (taken_count)
  );

  assign pc           = pc_q;
  assign fetch_valid  = fetch_valid_q;
  assign flush        = flush_q;
  assign halted       = halted_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: a default instance plus one with a
// top-of-memory reset PC and 2-bit counters for wrap and saturation.
module tb_pc_redirect_unit;

  logic        clk;
  logic        rst, stall, halt, br_issue, isBranch;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic        fetch_valid, flush, halted, misalign_err;
  logic [15:0] br_count, taken_count;

  logic        rst2, stall2, halt2, br_issue2, isBranch2;
  logic [31:0] br_target2;
  logic [31:0] pc2;
  logic        fetch_valid2, flush2, halted2, misalign_err2;
  logic [1:0]  br_count2, taken_count2;

  int n_checks = 0;
  int n_pass   = 0;

  pc_redirect_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .br_issue(br_issue),
    .br_target(br_target), .isBranch(isBranch), .pc(pc),
    .fetch_valid(fetch_valid), .flush(flush), .halted(halted),
    .misalign_err(misalign_err), .br_count(br_count), .taken_count(taken_count)
  );

  pc_redirect_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_INC(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .stall(stall2), .halt(halt2), .br_issue(br_issue2),
    .br_target(br_target2), .isBranch(isBranch2), .pc(pc2),
    .fetch_valid(fetch_valid2), .flush(flush2), .halted(halted2),
    .misalign_err(misalign_err2), .br_count(br_count2), .taken_count(taken_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; halt = 1'b0; br_issue = 1'b0;
    isBranch = 1'b0; br_target = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Reset, then run until pc=8 is presented with fetch_valid
  task automatic goto_pc8();
    do_reset();
    tick();
    tick();
    tick();
  endtask

  initial begin
    rst2 = 1'b0; stall2 = 1'b0; halt2 = 1'b0; br_issue2 = 1'b0;
    isBranch2 = 1'b0; br_target2 = '0;

    // Reset state
    rst = 1'b0; stall = 1'b0; halt = 1'b0; br_issue = 1'b0;
    isBranch = 1'b0; br_target = '0;
    tick();
    tick();
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_fv", fetch_valid, 0);
    check_eq("rst_flush", flush, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_misalign", misalign_err, 0);
    check_eq("rst_brcnt", br_count, 0);
    check_eq("rst_tkcnt", taken_count, 0);
    rst = 1'b1;

    // Sequential fetch after release: 0,4,8,12
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("seq_pc%0d", i), pc, 32'(4 * i));
      check_eq($sformatf("seq_fv%0d", i), fetch_valid, 1);
      check_eq($sformatf("seq_flush%0d", i), flush, 0);
    end

    // Taken branch at pc=8 to 0x40
    goto_pc8();
    check_eq("tk_pre_pc", pc, 32'h8);
    br_issue = 1'b1; br_target = 32'h40;
    tick();
    br_issue = 1'b0;
    check_eq("tk_bubble_pc", pc, 32'h8);
    check_eq("tk_bubble_fv", fetch_valid, 0);
    check_eq("tk_bubble_flush", flush, 0);
    isBranch = 1'b1;
    tick();
    isBranch = 1'b0;
    check_eq("tk_pc", pc, 32'h40);
    check_eq("tk_flush", flush, 1);
    check_eq("tk_fv", fetch_valid, 1);
    check_eq("tk_brcnt", br_count, 1);
    check_eq("tk_tkcnt", taken_count, 1);
    tick();
    check_eq("tk_flush_end", flush, 0);
    check_eq("tk_next_pc", pc, 32'h44);

    // Not-taken branch at pc=8: 8,8,12
    goto_pc8();
    br_issue = 1'b1; br_target = 32'h40;
    tick();
    br_issue = 1'b0;
    check_eq("nt_bubble_pc", pc, 32'h8);
    isBranch = 1'b0;
    tick();
    check_eq("nt_pc", pc, 32'hC);
    check_eq("nt_flush", flush, 0);
    check_eq("nt_fv", fetch_valid, 1);
    check_eq("nt_brcnt", br_count, 1);
    check_eq("nt_tkcnt", taken_count, 0);

    // Misaligned taken target halts with sticky error
    goto_pc8();
    br_issue = 1'b1; br_target = 32'h42;
    tick();
    br_issue = 1'b0; isBranch = 1'b1;
    tick();
    isBranch = 1'b0;
    check_eq("mis_err", misalign_err, 1);
    check_eq("mis_halted", halted, 1);
    check_eq("mis_pc", pc, 32'h8);
    check_eq("mis_flush", flush, 1);
    check_eq("mis_fv", fetch_valid, 0);
    check_eq("mis_tkcnt", taken_count, 1);
    br_issue = 1'b1; br_target = 32'h100;
    for (int i = 0; i < 3; i++) tick();
    br_issue = 1'b0;
    check_eq("mis_hold_pc", pc, 32'h8);
    check_eq("mis_hold_fv", fetch_valid, 0);
    check_eq("mis_hold_flush", flush, 0);
    check_eq("mis_hold_err", misalign_err, 1);

    // Halt beats a simultaneous branch issue
    goto_pc8();
    halt = 1'b1; br_issue = 1'b1; br_target = 32'h40;
    tick();
    halt = 1'b0; br_issue = 1'b0; isBranch = 1'b1;
    check_eq("hb_halted", halted, 1);
    check_eq("hb_fv", fetch_valid, 0);
    tick();
    isBranch = 1'b0;
    check_eq("hb_pc", pc, 32'h8);
    check_eq("hb_flush", flush, 0);
    check_eq("hb_brcnt", br_count, 0);
    check_eq("hb_tkcnt", taken_count, 0);

    // Stall holds pc and ignores br_issue
    goto_pc8();
    stall = 1'b1; br_issue = 1'b1; br_target = 32'h40;
    tick();
    check_eq("st_pc", pc, 32'h8);
    check_eq("st_fv", fetch_valid, 1);
    stall = 1'b0; br_issue = 1'b0;
    tick();
    check_eq("st_next_pc", pc, 32'hC);
    tick();
    check_eq("st_brcnt", br_count, 0);

    // Reset during RESOLVE discards the pending branch
    goto_pc8();
    br_issue = 1'b1; br_target = 32'h40;
    tick();
    br_issue = 1'b0; rst = 1'b0; isBranch = 1'b1;
    tick();
    isBranch = 1'b0;
    check_eq("rr_pc", pc, 32'h0);
    check_eq("rr_flush", flush, 0);
    check_eq("rr_brcnt", br_count, 0);
    check_eq("rr_tkcnt", taken_count, 0);
    rst = 1'b1;
    tick();
    check_eq("rr_run_pc", pc, 32'h0);
    check_eq("rr_run_fv", fetch_valid, 1);
    tick();
    check_eq("rr_run_pc2", pc, 32'h4);
    check_eq("rr_run_flush", flush, 0);

    // Second instance: PC wrap and counter saturation with CNT_W=2
    rst2 = 1'b0;
    tick();
    tick();
    check_eq("wr_rst_pc", pc2, 32'hFFFF_FFFC);
    rst2 = 1'b1;
    tick();
    check_eq("wr_first_pc", pc2, 32'hFFFF_FFFC);
    check_eq("wr_first_fv", fetch_valid2, 1);
    tick();
    check_eq("wr_wrap_pc", pc2, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      br_issue2 = 1'b1; br_target2 = 32'h100;
      tick();
      br_issue2 = 1'b0; isBranch2 = 1'b1;
      tick();
      isBranch2 = 1'b0;
      check_eq($sformatf("sat_pc%0d", i), pc2, 32'h100);
      check_eq($sformatf("sat_tk%0d", i), taken_count2, (i > 3) ? 32'd3 : 32'(i));
      check_eq($sformatf("sat_br%0d", i), br_count2, (i > 3) ? 32'd3 : 32'(i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
